// File: rtl/mac_mul_sequencer_pkg.sv
// ============================================================================
// Module   : mac_mul_sequencer_pkg
// Brief    : FSM state encoding, cfg codes and cfg helpers for the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mac_mul_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] CFG_SINGLE = 2'b00;
  localparam logic [1:0] CFG_DUAL   = 2'b01;
  localparam logic [1:0] CFG_QUAD   = 2'b10;
  localparam logic [1:0] CFG_RSVD   = 2'b11;

  // The reserved code is executed (and reported) as a single-byte operation.
  function automatic logic [1:0] cfg_normalize(input logic [1:0] cfg);
    return (cfg == CFG_RSVD) ? CFG_SINGLE : cfg;
  endfunction

  function automatic logic [1:0] cfg_last_beat(input logic [1:0] cfg);
    case (cfg)
      CFG_DUAL: return 2'd1;
      CFG_QUAD: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_mul_sequencer_beat_ctr.sv
// ============================================================================
// Module   : mac_mul_beat_ctr
// Brief    : Beat index counter with terminal-count flag against last_i.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_mul_beat_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic [1:0] last_i,
  output logic [1:0] k_o,
  output logic       tc_o
);

  logic [1:0] k_q;
  logic [1:0] k_d;

  always_comb begin
    k_d = k_q;
    if (clr_i) begin
      k_d = '0;
    end else if (inc_i) begin
      k_d = k_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k_o  = k_q;
  assign tc_o = (k_q == last_i);

endmodule

`default_nettype wire

// File: rtl/mac_mul_sequencer.sv
// ============================================================================
// Module   : mac_mul_sequencer
// Brief    : Byte-serial multiply sequencer; accumulates shifted partial
//            products returned by an external A*byte multiply block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mac_mul_sequencer
  import mac_mul_sequencer_pkg::*;
#(
  parameter int MAC_CONF_WIDTH = 2,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_INT_WIDTH  = 5 * MAC_MIN_WIDTH,
  parameter int MAC_PROD_WIDTH = 8 * MAC_MIN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0]  in_a,
  input  logic [4*MAC_MIN_WIDTH-1:0]  in_b,
  input  logic [MAC_CONF_WIDTH-1:0]   in_cfg,
  output logic [MAC_MIN_WIDTH-1:0]    mul_a0,
  output logic [MAC_MIN_WIDTH-1:0]    mul_a1,
  output logic [MAC_MIN_WIDTH-1:0]    mul_a2,
  output logic [MAC_MIN_WIDTH-1:0]    mul_a3,
  output logic [MAC_MIN_WIDTH-1:0]    mul_b0,
  output logic [MAC_CONF_WIDTH-1:0]   mul_cfg,
  input  logic [MAC_INT_WIDTH-1:0]    mul_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAC_PROD_WIDTH-1:0]   out_prod,
  output logic [MAC_CONF_WIDTH-1:0]   out_cfg
);

  localparam int C_OP_WIDTH = 4 * MAC_MIN_WIDTH;

  state_t                    state_q, state_d;
  logic [C_OP_WIDTH-1:0]     a_q, a_d;
  logic [C_OP_WIDTH-1:0]     b_q, b_d;
  logic [MAC_CONF_WIDTH-1:0] cfg_q, cfg_d;
  logic [MAC_PROD_WIDTH-1:0] acc_q, acc_d;

  logic                      w_run;
  logic                      w_clr;
  logic                      w_inc;
  logic                      w_tc;
  logic [1:0]                w_k;
  logic [1:0]                w_last;
  logic [MAC_CONF_WIDTH-1:0] w_cfg_norm;
  logic [MAC_PROD_WIDTH-1:0] w_beat_term;
  logic [MAC_MIN_WIDTH-1:0]  w_b_byte;
  logic [MAC_MIN_WIDTH-1:0]  w_a_byte [4];

  assign w_run      = (state_q == ST_RUN);
  assign w_cfg_norm = MAC_CONF_WIDTH'(cfg_normalize(in_cfg[1:0]));
  assign w_last     = cfg_last_beat(cfg_q[1:0]);

  mac_mul_beat_ctr u_beat_ctr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (w_clr),
    .inc_i  (w_inc),
    .last_i (w_last),
    .k_o    (w_k),
    .tc_o   (w_tc)
  );

  // Beat k selects B byte k and weights the returned partial product by 2^(8k).
  always_comb begin
    w_beat_term = '0;
    w_b_byte    = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_k == 2'(i)) begin
        w_beat_term = MAC_PROD_WIDTH'(mul_c) << (i * MAC_MIN_WIDTH);
        w_b_byte    = b_q[i*MAC_MIN_WIDTH +: MAC_MIN_WIDTH];
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_a_byte
    assign w_a_byte[gi] = (w_run && (2'(gi) <= w_last))
                        ? a_q[gi*MAC_MIN_WIDTH +: MAC_MIN_WIDTH] : '0;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cfg_d   = cfg_q;
    acc_d   = acc_q;
    w_clr   = 1'b0;
    w_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cfg_d   = w_cfg_norm;
          acc_d   = '0;
          w_clr   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (en) begin
          acc_d = acc_q + w_beat_term;
          w_inc = 1'b1;
          if (w_tc) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cfg_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cfg_q   <= cfg_d;
      acc_q   <= acc_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_prod  = out_valid ? acc_q : '0;
  assign out_cfg   = out_valid ? cfg_q : '0;

  assign mul_a0  = w_a_byte[0];
  assign mul_a1  = w_a_byte[1];
  assign mul_a2  = w_a_byte[2];
  assign mul_a3  = w_a_byte[3];
  assign mul_b0  = w_run ? w_b_byte : '0;
  assign mul_cfg = w_run ? cfg_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mac_mul_sequencer.sv
// ============================================================================
// Module   : tb_mac_mul_sequencer
// Brief    : Self-checking bench: directed and random operations against an
//            arithmetic reference; the multiply block is modelled here.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mac_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_cfg;
  logic [7:0]  mul_a0, mul_a1, mul_a2, mul_a3, mul_b0;
  logic [1:0]  mul_cfg;
  logic [39:0] mul_c;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic [1:0]  out_cfg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External multiply block: unsigned {A bytes} * current B byte.
  assign mul_c = 40'({mul_a3, mul_a2, mul_a1, mul_a0}) * 40'(mul_b0);

  mac_mul_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cfg    (in_cfg),
    .mul_a0    (mul_a0),
    .mul_a1    (mul_a1),
    .mul_a2    (mul_a2),
    .mul_a3    (mul_a3),
    .mul_b0    (mul_b0),
    .mul_cfg   (mul_cfg),
    .mul_c     (mul_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_cfg   (out_cfg)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input logic [1:0] cfg);
    return (cfg == 2'b01) ? 2 : (cfg == 2'b10) ? 4 : 1;
  endfunction

  function automatic logic [1:0] cfg_of(input logic [1:0] cfg);
    return (cfg == 2'b11) ? 2'b00 : cfg;
  endfunction

  task automatic check_mul_idle(input string tag);
    check_val(tag, 64'({mul_a3, mul_a2, mul_a1, mul_a0, mul_b0, mul_cfg}), 64'd0);
  endtask

  // One full transaction. Stall window covers RUN cycles [stall_at, stall_at+stall_len).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] cfg,
                       input int stall_at, input int stall_len, input int ready_wait);
    int          n;
    int          k;
    int          lat;
    bit          seen;
    logic [63:0] mask;
    logic [63:0] exp_p;
    logic [31:0] am;
    n     = beats_of(cfg);
    mask  = (64'd1 << (8 * n)) - 64'd1;
    exp_p = (64'(a) & mask) * (64'(b) & mask);
    am    = 32'(64'(a) & mask);
    lat   = -1;
    seen  = 1'b0;
    k     = 0;

    @(negedge clk);
    check_val("idle_in_ready", 64'(in_ready), 64'd1);
    check_mul_idle("idle_mul_zero");
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_cfg    = cfg;
    en        = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_cfg   = 2'($urandom);

    for (int cyc = 1; cyc <= 24 && !seen; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = cyc;
      end else begin
        check_val("run_in_ready", 64'(in_ready), 64'd0);
        check_val("run_mul_b0", 64'(mul_b0), 64'(8'(b >> (8 * k))));
        check_val("run_mul_a", 64'({mul_a3, mul_a2, mul_a1, mul_a0}), 64'(am));
        check_val("run_mul_cfg", 64'(mul_cfg), 64'(cfg_of(cfg)));
        en = !(cyc >= stall_at && cyc < stall_at + stall_len);
        if (en) k++;
      end
    end
    en = 1'b1;
    check_val("latency", 64'(lat), 64'(n + 1 + stall_len));
    if (!seen) return;

    check_val("done_prod", out_prod, exp_p);
    check_val("done_cfg", 64'(out_cfg), 64'(cfg_of(cfg)));
    check_val("done_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < ready_wait; i++) begin
      @(negedge clk);
      check_val("hold_valid", 64'(out_valid), 64'd1);
      check_val("hold_prod", out_prod, exp_p);
      check_val("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("ret_in_ready", 64'(in_ready), 64'd1);
    check_val("ret_out_valid", 64'(out_valid), 64'd0);
    check_mul_idle("ret_mul_zero");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cfg    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_prod", out_prod, 64'd0);
    check_val("rst_out_cfg", 64'(out_cfg), 64'd0);
    check_mul_idle("rst_mul_zero");
    rst = 1'b0;

    do_op(32'h0000_00FF, 32'h0000_0003, 2'b00, 0, 0, 0);
    do_op(32'h0000_1234, 32'h0000_5678, 2'b01, 0, 0, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0, 0, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2, 2, 0);
    do_op(32'hDEAD_BEEF, 32'h0123_4567, 2'b10, 0, 0, 3);
    do_op(32'hABCD_EF12, 32'h3456_789A, 2'b11, 0, 0, 1);

    // Reset while quad beat 2 is presented: operation must vanish.
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = 32'hFFFF_FFFF;
    in_b     = 32'hFFFF_FFFF;
    in_cfg   = 2'b10;
    en       = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("pre_rst_mul_b0", 64'(mul_b0), 64'hFF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("post_rst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("post_rst_no_valid", 64'(out_valid), 64'd0);
    end
    do_op(32'h0000_0010, 32'h0000_0010, 2'b00, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] c;
      int         nb;
      c  = 2'($urandom_range(0, 3));
      nb = beats_of(c);
      do_op($urandom, $urandom, c, int'($urandom_range(1, nb)),
            int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
